// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, oversampling constants and baud divider helper
// for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK,
        PARITY
    } rx_state_e;

    localparam int OVERSAMPLE_C = 16;
    localparam int MID_SAMPLE_C = 8;

    // Clocks per oversample tick, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud * (OVERSAMPLE_C / 2)) / (baud * OVERSAMPLE_C);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: show-ahead FIFO; the head entry is presented on pop_data while
// the FIFO is non-empty. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Empty reads as zero so the head output is defined out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; entries are only read once written,
    // and leaving it reset-free lets it map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap modulo DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a show-ahead FIFO,
// with sticky frame_err/overrun flags and break detection.
// Optional build macro UART_RX_PARITY_EN: 8E1 framing with a sticky parity_err output.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        err_clr,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    output logic                        break_det
);

    import uart_pkg::*;

    localparam int              DIV      = calc_div(CLK_HZ, BAUD);
    localparam int              DW       = $clog2(DIV);
    localparam int              SW       = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0]   MID_LAST = SW'(MID_SAMPLE_C - 1);
    localparam logic [SW-1:0]   BIT_LAST = SW'(OVERSAMPLE_C - 1);

    rx_state_e      state, state_d;
    logic           rx_s1, rx_s2, rx_prev;
    logic [1:0]     fill;
    logic [DW-1:0]  baud_cnt;
    logic [SW-1:0]  samp_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           tick, start_edge, mid_start, full_bit;
    logic           rephase, samp_clr, bit_clr, shift_en;
    logic           byte_push, frame_set, ovr_set;
    logic           fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic           par_load, par_bad, par_mismatch;
`endif

    assign tick       = (baud_cnt == DIV_LAST);
    assign start_edge = rx_prev && !rx_s2;
    assign mid_start  = tick && (samp_cnt == MID_LAST);
    assign full_bit   = tick && (samp_cnt == BIT_LAST);
    assign break_det  = (state == BREAK);
    assign rx_valid   = !fifo_empty;
    assign ovr_set    = byte_push && fifo_full && !(rx_valid && rx_ready);

    // Two-flop synchronizer plus edge history. fill marks when the chain holds
    // real line samples, so a line already low at reset release is not a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            fill    <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its
            // pre-edge input, which is what builds a real shift chain here.
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            fill    <= {fill[0], 1'b1};
            rx_prev <= fill[1] && rx_s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d   = state;
        rephase   = 1'b0;
        samp_clr  = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        byte_push = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_load  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_d  = START;
                    rephase  = 1'b1;
                    samp_clr = 1'b1;
                end
            end
            START: begin
                if (mid_start) begin
                    samp_clr = 1'b1;
                    if (rx_s2) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_clr = 1'b1;
                    end
                end
            end
            DATA: begin
                if (full_bit) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_bit) begin
                    par_load = 1'b1;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (full_bit) begin
                    if (rx_s2) begin
`ifdef UART_RX_PARITY_EN
                        byte_push = !par_bad;
`else
                        byte_push = 1'b1;
`endif
                        state_d   = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Baud tick counter, sample counter, bit index and LSB-first shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            samp_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            if (rephase || tick) baud_cnt <= '0;
            else                 baud_cnt <= baud_cnt + DW'(1);
            if (samp_clr)  samp_cnt <= '0;
            else if (tick) samp_cnt <= samp_cnt + SW'(1);
            if (bit_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg <= {rx_s2, shreg[7:1]};
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ovr_set)      overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_mismatch = rx_s2 ^ (^shreg);

    // Even-parity check of the received byte and its sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_load) par_bad <= par_mismatch;
            if (par_load && par_mismatch) parity_err <= 1'b1;
            else if (err_clr)             parity_err <= 1'b0;
        end
    end
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (byte_push),
        .push_data (shreg),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks drive serial frames into uart_rx_fifo and
// compare the byte stream and flags against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int TB_CLK_HZ  = 20_275_200;
    localparam int TB_BAUD    = 115_200;
    localparam int FIFO_DEPTH = 16;
    // 20_275_200 / (115_200 * 16) is exactly 11 clocks per oversample tick.
    localparam int DIV = 11;
    localparam int BIT = 16 * DIV;
    // Start edge to byte visible: 2 sync flops + edge register, then 8 ticks
    // to mid start bit and 9 further bit periods to mid stop bit.
    localparam int LAT = 3 + DIV * (8 + 16 * 9);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic       rx_ready;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       break_det;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rise_cyc = -1;
    logic       prev_v = 1'b0;
    logic [7:0] q[$];
    logic       ovr_exp = 1'b0;

    uart_rx_fifo #(
        .CLK_HZ     (TB_CLK_HZ),
        .BAUD       (TB_BAUD),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .break_det  (break_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle at which rx_valid rises.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && prev_v === 1'b0) rise_cyc = cyc;
        prev_v = rx_valid;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            wait_clk(BIT);
        end
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (q.size() == FIFO_DEPTH) ovr_exp = 1'b1;
        else                        q.push_back(b);
    endfunction

    task automatic drain();
        logic [7:0] want;
        while (q.size() > 0) begin
            want = q.pop_front();
            n_cmp++;
            if (rx_valid !== 1'b1 || rx_data !== want) begin
                n_bad++;
                $display("FAIL drain_head: got valid=%0b data=%02h want valid=1 data=%02h", rx_valid, rx_data, want);
            end
            rx_ready = 1'b1;
            wait_clk(1);
            rx_ready = 1'b0;
            n_cmp++;
            if (fifo_count !== 5'(q.size())) begin
                n_bad++;
                $display("FAIL drain_count: got %0d want %0d", fifo_count, q.size());
            end
        end
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: got valid=%0b want 0", rx_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
        wait_clk(5);
        n_cmp++; if (rx_data !== 8'h00)    begin n_bad++; $display("FAIL reset_rx_data: got %02h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_rx_valid: got %0b want 0", rx_valid); end
        n_cmp++; if (fifo_count !== 5'd0)  begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (frame_err !== 1'b0)   begin n_bad++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0)     begin n_bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
        n_cmp++; if (break_det !== 1'b0)   begin n_bad++; $display("FAIL reset_break_det: got %0b want 0", break_det); end
        rst_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_basic();
        int c0;
        rise_cyc = -1;
        c0 = cyc;
        send_frame(8'h55, 1'b1);
        model_push(8'h55);
        n_cmp++; if (rise_cyc - c0 !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - c0, LAT); end
        n_cmp++; if (rx_data !== 8'h55)     begin n_bad++; $display("FAIL basic_data: got %02h want 55", rx_data); end
        n_cmp++; if (fifo_count !== 5'(q.size())) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", fifo_count, q.size()); end
        drain();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        n_cmp++; if (fifo_count !== 5'd0 || rx_valid !== 1'b0) begin n_bad++; $display("FAIL pop_empty: got count=%0d valid=%0b want 0/0", fifo_count, rx_valid); end
        wait_clk(20);
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0;
        wait_clk(5);
        uart_rx = 1'b1;
        wait_clk(2 * BIT);
        n_cmp++; if (rx_valid !== 1'b0 || fifo_count !== 5'd0) begin n_bad++; $display("FAIL glitch_push: got valid=%0b count=%0d want 0/0", rx_valid, fifo_count); end
        n_cmp++; if ({frame_err, overrun, break_det} !== 3'b000) begin n_bad++; $display("FAIL glitch_flags: got %03b want 000", {frame_err, overrun, break_det}); end
    endtask

    task automatic test_frame_break();
        send_frame(8'hA3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            wait_clk(200);
            n_cmp++; if (break_det !== 1'b1) begin n_bad++; $display("FAIL break_hold: got %0b want 1 at step %0d", break_det, i); end
        end
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL frame_err_set: got %0b want 1", frame_err); end
        n_cmp++; if (rx_valid !== 1'b0)  begin n_bad++; $display("FAIL frame_no_push: got valid=%0b want 0", rx_valid); end
        uart_rx = 1'b1;
        wait_clk(5);
        n_cmp++; if (break_det !== 1'b0 || frame_err !== 1'b1) begin n_bad++; $display("FAIL break_release: got break=%0b frame=%0b want 0/1", break_det, frame_err); end
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL err_clr_frame: got %0b want 0", frame_err); end
        wait_clk(2 * BIT);
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1);
            model_push(8'(i));
        end
        n_cmp++; if (fifo_count !== 5'(q.size())) begin n_bad++; $display("FAIL overrun_count: got %0d want %0d", fifo_count, q.size()); end
        n_cmp++; if (overrun !== ovr_exp)         begin n_bad++; $display("FAIL overrun_flag: got %0b want %0b", overrun, ovr_exp); end
        n_cmp++; if (rx_data !== q[0])            begin n_bad++; $display("FAIL overrun_head: got %02h want %02h", rx_data, q[0]); end
    endtask

    task automatic test_full_push_pop();
        int c0;
        logic [7:0] head;
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        ovr_exp = 1'b0;
        n_cmp++; if (overrun !== ovr_exp) begin n_bad++; $display("FAIL err_clr_overrun: got %0b want %0b", overrun, ovr_exp); end
        wait_clk(BIT);
        c0 = cyc;
        fork
            send_frame(8'h11, 1'b1);
            begin
                wait_clk(LAT - 1);
                head = q.pop_front();
                n_cmp++; if (rx_data !== head) begin n_bad++; $display("FAIL pushpop_head: got %02h want %02h", rx_data, head); end
                rx_ready = 1'b1;
                wait_clk(1);
                rx_ready = 1'b0;
                model_push(8'h11);
                n_cmp++; if (fifo_count !== 5'(q.size())) begin n_bad++; $display("FAIL pushpop_count: got %0d want %0d", fifo_count, q.size()); end
            end
        join
        n_cmp++; if (overrun !== ovr_exp) begin n_bad++; $display("FAIL pushpop_overrun: got %0b want %0b (start cycle %0d)", overrun, ovr_exp, c0); end
        drain();
    endtask

    task automatic test_random();
        logic [7:0] b;
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            uart_rx = 1'b1;
            wait_clk($urandom_range(1, 3 * DIV));
            send_frame(b, 1'b1);
            model_push(b);
        end
        n_cmp++; if (fifo_count !== 5'(q.size())) begin n_bad++; $display("FAIL random_count: got %0d want %0d", fifo_count, q.size()); end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h77, 1'b1);
        model_push(8'h77);
        uart_rx = 1'b0;
        wait_clk(BIT);
        uart_rx = 1'b1;
        wait_clk(4 * BIT + BIT / 2);
        rst_n = 1'b0;
        uart_rx = 1'b0;
        q.delete();
        ovr_exp = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({rx_valid, rx_data, fifo_count, frame_err, overrun, break_det} !== 17'd0) begin
                n_bad++;
                $display("FAIL reset_hold: got valid=%0b data=%02h count=%0d flags=%03b want all 0", rx_valid, rx_data, fifo_count, {frame_err, overrun, break_det});
            end
            wait_clk(1);
        end
        rst_n = 1'b1;
        wait_clk(3 * BIT);
        uart_rx = 1'b1;
        wait_clk(2 * BIT);
        send_frame(8'h3C, 1'b1);
        model_push(8'h3C);
        n_cmp++; if (fifo_count !== 5'(q.size())) begin n_bad++; $display("FAIL post_reset_count: got %0d want %0d", fifo_count, q.size()); end
        drain();
        n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_bad++; $display("FAIL post_reset_flags: got %02b want 00", {frame_err, overrun}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_break();
        test_overrun();
        test_full_push_pop();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
